// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler
//
// Purpose:
//   Per-beam rising-edge scalers for the beamformer trigger bits. The scalers are
//   gated by a programmable period. At the end of each gate the live counts move to
//   a latched bank that a simple strobe/address port reads. A combined masked
//   trigger output is also produced.
//
// Build option:
//   BEAM_SCALER_HOLDOFF_EN - when defined, trig_o goes through an IDLE/HOLD FSM.
//     After each accepted trigger it suppresses further triggers for HOLDOFF
//     clocks. When undefined, trig_o is the registered combined event of every
//     clock.
//
// Ports:
//   clk_i       - beamformer clock
//   rst_i       - synchronous active-high reset
//   trigger_i   - per-beam trigger bits (NBEAMS)
//   mask_i      - 1 excludes the beam from trig_o; its scaler still counts
//   period_i    - gate length in clocks minus 1, sampled at each gate load
//   rd_i        - single-cycle read strobe
//   rd_addr_i   - beam index to read; indices >= NBEAMS read as 0
//   rd_valid_o  - read data valid, one clock after rd_i
//   rd_data_o   - latched scaler value
//   gate_done_o - one-cycle pulse when the latched bank updates
//   trig_o      - combined masked trigger

module beam_trigger_scaler #(
  parameter int unsigned NBEAMS   = 2,
  parameter int unsigned NCNTBITS = 16,
  parameter int unsigned HOLDOFF  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NBEAMS-1:0]   trigger_i,
  input  logic [NBEAMS-1:0]   mask_i,
  input  logic [23:0]         period_i,
  input  logic                rd_i,
  input  logic [5:0]          rd_addr_i,
  output logic                rd_valid_o,
  output logic [NCNTBITS-1:0] rd_data_o,
  output logic                gate_done_o,
  output logic                trig_o
);

  if (NBEAMS < 1 || NBEAMS > 48) begin : g_bad_nbeams
    $error("NBEAMS must be in 1..48");
  end
  if (NCNTBITS < 1) begin : g_bad_ncntbits
    $error("NCNTBITS must be at least 1");
  end
  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("HOLDOFF must be in 1..255");
  end

  localparam logic [NCNTBITS-1:0] CntMax = '1;
  localparam logic [NCNTBITS-1:0] CntOne = NCNTBITS'(1);

  logic [NBEAMS-1:0]   r_trig_hist;
  logic [NBEAMS-1:0]   w_event;
  logic                w_comb_event;

  logic [NCNTBITS-1:0] r_live    [NBEAMS];
  logic [NCNTBITS-1:0] r_latched [NBEAMS];
  logic [NCNTBITS-1:0] w_live_inc[NBEAMS];

  logic [23:0]         r_gate;
  logic                r_gate_load;
  logic                w_gate_term;
  logic                r_gate_done;

  logic                r_rd_valid;
  logic [NCNTBITS-1:0] r_rd_data;
  logic [NCNTBITS-1:0] w_rd_mux;

  logic                r_trig;

  // History resets to 0, so a bit already high on the first clock after reset counts.
  assign w_event      = trigger_i & ~r_trig_hist;
  assign w_comb_event = |(w_event & ~mask_i);

  // The load clock after reset is never a terminal count, even if period_i is 0.
  assign w_gate_term  = ~r_gate_load && (r_gate == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trig_hist <= '0;
    end else begin
      r_trig_hist <= trigger_i;
    end
  end

  // Saturating increment. This value is also what gets latched, so an event on the
  // terminal clock lands in the closing gate.
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      w_live_inc[b] = r_live[b];
      if (w_event[b] && (r_live[b] != CntMax)) begin
        w_live_inc[b] = r_live[b] + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gate      <= '0;
      r_gate_load <= 1'b1;
      r_gate_done <= 1'b0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_live[b]    <= '0;
        r_latched[b] <= '0;
      end
    end else begin
      r_gate_done <= w_gate_term;
      if (r_gate_load) begin
        r_gate      <= period_i;
        r_gate_load <= 1'b0;
      end else if (w_gate_term) begin
        r_gate <= period_i;
      end else begin
        r_gate <= r_gate - 24'd1;
      end
      for (int b = 0; b < NBEAMS; b++) begin
        if (w_gate_term) begin
          r_latched[b] <= w_live_inc[b];
          r_live[b]    <= '0;
        end else begin
          r_live[b] <= w_live_inc[b];
        end
      end
    end
  end

  // Out-of-range addresses match no beam and read as 0.
  always_comb begin
    w_rd_mux = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (rd_addr_i == 6'(b)) begin
        w_rd_mux = r_latched[b];
      end
    end
  end

  // Reads the bank before this clock's update, so a read that coincides with a
  // gate end returns the previous gate's value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (rd_i) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_mux;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end
  end

`ifdef BEAM_SCALER_HOLDOFF_EN
  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLDOFF - 1);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
  logic       w_trig_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_trig     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_trig     <= w_trig_nxt;
    end
  end

  // HOLD spans exactly HOLDOFF clocks. The count runs HOLDOFF-1 down to 0 and then
  // exits, so the first IDLE clock can accept a new event.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_trig_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_comb_event) begin
          w_state_nxt    = StHold;
          w_hold_cnt_nxt = HoldLast;
          w_trig_nxt     = 1'b1;
        end
      end
      StHold: begin
        if (r_hold_cnt == '0) begin
          w_state_nxt = StIdle;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
        end
      end
    endcase
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trig <= 1'b0;
    end else begin
      r_trig <= w_comb_event;
    end
  end
`endif

  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;
  assign gate_done_o = r_gate_done;
  assign trig_o      = r_trig;

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed testbench for beam_trigger_scaler. The main instance uses NBEAMS=2,
// NCNTBITS=16 and HOLDOFF=8. A second instance with NCNTBITS=4 shares all of the
// inputs and is compared only for saturation and reset behaviour. Expected trig_o
// timing follows BEAM_SCALER_HOLDOFF_EN.

module tb_beam_trigger_scaler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  trig;
  logic [1:0]  mask;
  logic [23:0] period;
  logic        rd;
  logic [5:0]  addr;

  logic        rd_valid;
  logic [15:0] rd_data;
  logic        gate_done;
  logic        trig_o;

  logic        rd_valid_s;
  logic [3:0]  rd_data_s;
  logic        gate_done_s;
  logic        trig_o_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  beam_trigger_scaler #(
    .NBEAMS  (2),
    .NCNTBITS(16),
    .HOLDOFF (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .trigger_i  (trig),
    .mask_i     (mask),
    .period_i   (period),
    .rd_i       (rd),
    .rd_addr_i  (addr),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .gate_done_o(gate_done),
    .trig_o     (trig_o)
  );

  beam_trigger_scaler #(
    .NBEAMS  (2),
    .NCNTBITS(4),
    .HOLDOFF (8)
  ) dut_sat (
    .clk_i      (clk),
    .rst_i      (rst),
    .trigger_i  (trig),
    .mask_i     (mask),
    .period_i   (period),
    .rd_i       (rd),
    .rd_addr_i  (addr),
    .rd_valid_o (rd_valid_s),
    .rd_data_o  (rd_data_s),
    .gate_done_o(gate_done_s),
    .trig_o     (trig_o_s)
  );

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return is just after the last reset edge. The next edge is the gate load clock.
  task automatic do_reset(input logic [23:0] p);
    rst    = 1'b1;
    trig   = '0;
    mask   = '0;
    rd     = 1'b0;
    addr   = '0;
    period = p;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic read_beam(input logic [5:0] a);
    addr = a;
    rd   = 1'b1;
    step();
    rd   = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] bits);
    trig = bits;
    step();
    trig = '0;
    step();
  endtask

  task automatic wait_gate_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (gate_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 2'b11; mask = '0; period = 24'd0; rd = 1'b1; addr = '0;
    repeat (2) step();
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %0b need 0", rd_valid); end
    n_cmp++;
    if (rd_data !== 16'd0) begin n_bad++; $display("FAIL reset_rd_data: got %0d need 0", rd_data); end
    n_cmp++;
    if (gate_done !== 1'b0 || gate_done_s !== 1'b0) begin
      n_bad++; $display("FAIL reset_gate_done: got %0b/%0b need 0/0", gate_done, gate_done_s);
    end
    n_cmp++;
    if (trig_o !== 1'b0 || trig_o_s !== 1'b0) begin
      n_bad++; $display("FAIL reset_trig_o: got %0b/%0b need 0/0", trig_o, trig_o_s);
    end
    // Hold trigger high through release. The first clock counts as an event.
    rd = 1'b0; rst = 1'b0;
    step();
    n_cmp++;
    if (gate_done !== 1'b0) begin n_bad++; $display("FAIL post_reset_load_gd: got %0b need 0", gate_done); end
    n_cmp++;
    if (trig_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_trig: got %0b need 1", trig_o); end
    step();
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL period0_first_gd: got %0b need 1", gate_done); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd1) begin
      n_bad++; $display("FAIL post_reset_count: got v=%0b d=%0d need v=1 d=1", rd_valid, rd_data);
    end
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL period0_every_clk: got %0b need 1", gate_done); end
    trig = '0;
  endtask

  task automatic test_gate_timing();
    bit exp;
    do_reset(24'd3);
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k == 5) || (k == 9);
      n_cmp++;
      if (gate_done !== exp) begin
        n_bad++; $display("FAIL gate_timing_clk%0d: got %0b need %0b", k, gate_done, exp);
      end
    end
  endtask

  task automatic test_gate_count();
    bit ok;
    do_reset(24'd99);
    for (int i = 0; i < 5; i++) pulse({(i < 3), 1'b1});
    wait_gate_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gate_count_done: got timeout need pulse"); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd5) begin
      n_bad++; $display("FAIL gate_count_b0: got v=%0b d=%0d need v=1 d=5", rd_valid, rd_data);
    end
    step();
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_single: got %0b need 0", rd_valid); end
    read_beam(6'd1);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd3) begin
      n_bad++; $display("FAIL gate_count_b1: got v=%0b d=%0d need v=1 d=3", rd_valid, rd_data);
    end
  endtask

  task automatic test_level_sat();
    bit ok;
    do_reset(24'd299);
    trig = 2'b01;
    repeat (200) step();
    trig = '0;
    wait_gate_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL level_done: got timeout need pulse"); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_data !== 16'd1) begin n_bad++; $display("FAIL level_count: got %0d need 1", rd_data); end
    do_reset(24'd99);
    repeat (20) pulse(2'b01);
    wait_gate_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL sat_done: got timeout need pulse"); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_data !== 16'd20) begin n_bad++; $display("FAIL count20_wide: got %0d need 20", rd_data); end
    n_cmp++;
    if (rd_valid_s !== 1'b1 || rd_data_s !== 4'd15) begin
      n_bad++; $display("FAIL saturate_4b: got v=%0b d=%0d need v=1 d=15", rd_valid_s, rd_data_s);
    end
  endtask

  task automatic test_boundary();
    do_reset(24'd9);
    trig = 2'b01; step();  // E1
    trig = '0;    step();  // E2
    trig = 2'b01; step();  // E3
    trig = '0;    step();  // E4
    repeat (6) step();     // E10
    n_cmp++;
    if (gate_done !== 1'b0) begin n_bad++; $display("FAIL bnd_early_gd: got %0b need 0", gate_done); end
    step();                // E11, first gate closes with 2
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL bnd_gate1_gd: got %0b need 1", gate_done); end
    repeat (3) step();     // E14
    trig = 2'b01; step();  // E15
    trig = '0;
    repeat (5) step();     // E20
    // Edge and read both land on the terminal clock E21.
    trig = 2'b01; rd = 1'b1; addr = 6'd0;
    step();
    trig = '0; rd = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd2) begin
      n_bad++; $display("FAIL bnd_read_prev: got v=%0b d=%0d need v=1 d=2", rd_valid, rd_data);
    end
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL bnd_gate2_gd: got %0b need 1", gate_done); end
    read_beam(6'd0);       // E22
    n_cmp++;
    if (rd_data !== 16'd2) begin n_bad++; $display("FAIL bnd_edge_counted: got %0d need 2", rd_data); end
    repeat (9) step();     // E31
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL bnd_gate3_gd: got %0b need 1", gate_done); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_data !== 16'd0) begin n_bad++; $display("FAIL bnd_next_gate_zero: got %0d need 0", rd_data); end
  endtask

  task automatic test_holdoff();
    bit exp;
    int c;
    do_reset(24'd1000);
    for (int cyc = 0; cyc < 25; cyc++) begin
      trig = ((cyc == 10) || (cyc == 14) || (cyc == 19)) ? 2'b01 : 2'b00;
      step();
      c = cyc + 1;
`ifdef BEAM_SCALER_HOLDOFF_EN
      exp = (c == 11) || (c == 20);
`else
      exp = (c == 11) || (c == 15) || (c == 20);
`endif
      n_cmp++;
      if (trig_o !== exp) begin
        n_bad++; $display("FAIL holdoff_clk%0d: got %0b need %0b", c, trig_o, exp);
      end
    end
    trig = '0;
  endtask

  task automatic test_mask_addr();
    bit ok;
    do_reset(24'd19);
    mask = 2'b01;
    trig = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      trig = '0;
      n_cmp++;
      if (trig_o !== 1'b0) begin n_bad++; $display("FAIL mask_trig_clk%0d: got %0b need 0", k, trig_o); end
    end
    wait_gate_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mask_done: got timeout need pulse"); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_data !== 16'd1) begin n_bad++; $display("FAIL mask_still_counts: got %0d need 1", rd_data); end
    read_beam(6'd5);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
      n_bad++; $display("FAIL addr_out_of_range: got v=%0b d=%0d need v=1 d=0", rd_valid, rd_data);
    end
    trig = 2'b10;
    step();
    trig = '0;
    n_cmp++;
    if (trig_o !== 1'b1) begin n_bad++; $display("FAIL unmasked_beam1: got %0b need 1", trig_o); end
    mask = '0;
  endtask

  task automatic test_reset_mid_gate();
    bit ok;
    int seen;
    do_reset(24'd9);
    trig = 2'b01; step();
    trig = '0; period = 24'd99;
    wait_gate_done(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rmg_first_done: got timeout need pulse"); end
    read_beam(6'd0);
    n_cmp++;
    if (rd_data !== 16'd1) begin n_bad++; $display("FAIL rmg_pre_value: got %0d need 1", rd_data); end
    seen = 0;
    pulse(2'b01);
    for (int k = 0; k < 47; k++) begin
      step();
      if (gate_done !== 1'b0) seen++;
    end
    rst = 1'b1;
    repeat (3) step();
    if (gate_done !== 1'b0) seen++;
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rmg_no_gate_done: got %0d pulses need 0", seen); end
    n_cmp++;
    if (rd_valid !== 1'b0 || trig_o !== 1'b0) begin
      n_bad++; $display("FAIL rmg_outputs_idle: got v=%0b t=%0b need 0/0", rd_valid, trig_o);
    end
    period = 24'd4;
    rst = 1'b0;
    addr = 6'd0; rd = 1'b1;
    step();                // E1: gate load
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
      n_bad++; $display("FAIL rmg_read_b0: got v=%0b d=%0d need v=1 d=0", rd_valid, rd_data);
    end
    addr = 6'd1;
    step();                // E2
    rd = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin
      n_bad++; $display("FAIL rmg_read_b1: got v=%0b d=%0d need v=1 d=0", rd_valid, rd_data);
    end
    seen = (gate_done !== 1'b0) ? 1 : 0;
    repeat (3) begin
      step();              // E3..E5
      if (gate_done !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rmg_early_gd: got %0d pulses need 0", seen); end
    step();                // E6: first post-reset gate of period_i+1 clocks ends
    n_cmp++;
    if (gate_done !== 1'b1) begin n_bad++; $display("FAIL rmg_restart_gd: got %0b need 1", gate_done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trig = '0; mask = '0; period = '0; rd = 1'b0; addr = '0;
    test_reset();
    test_gate_timing();
    test_gate_count();
    test_level_sat();
    test_boundary();
    test_holdoff();
    test_mask_addr();
    test_reset_mid_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/beam_trigger_scaler.md
BEAM_TRIGGER_SCALER -- requirements
Module: beam_trigger_scaler

Interface
REQ-001 SHALL have parameter NBEAMS, default 2: number of beam trigger inputs, range 1-48.
REQ-002 SHALL have parameter NCNTBITS, default 16: width of each per-beam scaler.
REQ-003 SHALL have parameter HOLDOFF, default 8: clocks during which trig_o is suppressed after a combined trigger, range 1-255.
REQ-004 SHALL have port clk_i, input, 1: the single clock, the beamformer clock.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port trigger_i, input, NBEAMS: per-beam trigger bits from the upstream beamformer, one bit per beam.
REQ-007 SHALL have port mask_i, input, NBEAMS: 1 = beam excluded from trig_o; scalers still count.
REQ-008 SHALL have port period_i, input, 24: gate length in clocks minus 1.
REQ-009 SHALL have port rd_i, input, 1: single-cycle read strobe.
REQ-010 SHALL have port rd_addr_i, input, 6: beam index to read.
REQ-011 SHALL have port rd_valid_o, output, 1: read data valid.
REQ-012 SHALL have port rd_data_o, output, NCNTBITS: latched scaler value.
REQ-013 SHALL have port gate_done_o, output, 1: one-cycle pulse when the latched bank updates.
REQ-014 SHALL have port trig_o, output, 1: combined masked trigger.

Function
REQ-015 SHALL register trigger_i each clock and define an event for beam b as trigger_i[b]=1 while the previous registered value is 0 (rising edge).
REQ-016 SHALL keep a live counter per beam, incremented by 1 per event and saturating at 2^NCNTBITS-1 with no wrap.
REQ-017 SHALL run a gate down-counter loaded with period_i and decremented each clock; period_i is sampled only at load.
REQ-018 SHALL, on the clock where the gate counter is 0:
  - copy all live counts, including an event occurring that same cycle, into the latched bank;
  - clear the live counters;
  - reload the gate counter from period_i;
  - pulse gate_done_o high on the next clock.
REQ-019 SHALL treat period_i=0 as a gate of 1 clock, updating every clock.
REQ-020 SHALL, on rd_i=1, drive rd_valid_o=1 and rd_data_o=latched[rd_addr_i] on the next clock, and rd_valid_o=0 otherwise.
REQ-021 SHALL return 0 with rd_valid_o=1 when rd_addr_i>=NBEAMS.
REQ-022 SHALL return the pre-update latched value when rd_i coincides with a bank update.
REQ-023 SHALL form the combined event as the OR of events over beams with mask_i[b]=0.
REQ-024 SHALL register the combined event into trig_o, giving a latency of 1 clock from the trigger_i rising edge to trig_o.
REQ-025 SHALL implement the trig_o FSM states IDLE and HOLD (when the holdoff is compiled in):
  - IDLE -> HOLD on a combined event, with trig_o=1 for exactly one clock;
  - HOLD counts HOLDOFF clocks with trig_o=0 and ignores events;
  - HOLD -> IDLE after HOLDOFF clocks;
  - an event on the first IDLE clock is accepted.
REQ-026 SHALL apply mask_i changes on the next combined-event evaluation, with no retroactive effect.

Reset
REQ-027 SHALL, while rst_i=1, clear all live and latched counters, the trigger_i history register and the holdoff counter; the FSM SHALL return to IDLE.
REQ-028 SHALL hold rd_valid_o=0, rd_data_o=0, gate_done_o=0 and trig_o=0 during reset.
REQ-029 SHALL load the gate counter from period_i on the first clock after rst_i deasserts.
REQ-030 SHALL, on a reset mid-gate, discard the partial gate and produce no gate_done_o pulse.
REQ-031 SHALL count trigger_i=1 on the first post-reset clock as an event, because the history register resets to 0.

Configuration
REQ-032 SHALL compile in the holdoff FSM of REQ-025 when macro BEAM_SCALER_HOLDOFF_EN is defined.
REQ-033 SHALL, without BEAM_SCALER_HOLDOFF_EN, drive trig_o as the registered combined event of every clock, ignore HOLDOFF and include no FSM.

Verification
REQ-034 SHALL check gate counting: NBEAMS=2, period_i=99, 5 rising edges on beam 0 and 3 on beam 1 within a gate -> after gate_done_o, reads of addr 0 and 1 return 5 and 3 with 1-clock latency.
REQ-035 SHALL check level versus edge and saturation: trigger_i[0] held high 200 clocks -> count 1; NCNTBITS=4 with 20 edges in one gate -> 15.
REQ-036 SHALL check the gate boundary: an edge on the terminal-count clock -> counted in the closing gate; the next gate starts at 0; rd_i on the same clock -> previous value returned.
REQ-037 SHALL check holdoff with macro defined: HOLDOFF=8, edges on beam 0 at clocks 10, 14 and 19 -> trig_o high at 11 and 20 only; without macro -> trig_o high at 11, 15 and 20.
REQ-038 SHALL check mask and address: mask_i=2'b01 with an edge on beam 0 only -> trig_o stays 0 while the scaler counts 1; rd_addr_i=5 -> rd_data_o=0 with rd_valid_o=1.
REQ-039 SHALL check reset mid-gate: rst_i asserted at clock 50 of a 100-clock gate -> no gate_done_o, all reads return 0, and the gate restarts from period_i after release.
